// File: rtl/blackjack_pkg.sv
// -----------------------------------------------------------------------------
// blackjack_pkg
// Shared definitions for the blackjack front end and core.
//   - Button index constants (hit/stand/double/finish) and channel count.
//   - Per-channel debounce state encoding.
//   - Default debounce length for 10 ms at 25 MHz.
//   - btn_priority_pick(): reduces a press vector to its single
//     highest-priority bit, used when BTN_PRIORITY_EN is defined.
// -----------------------------------------------------------------------------
package blackjack_pkg;

    localparam int unsigned BTN_HIT    = 0;
    localparam int unsigned BTN_STAND  = 1;
    localparam int unsigned BTN_DOUBLE = 2;
    localparam int unsigned BTN_FINISH = 3;
    localparam int unsigned N_BTN      = 4;

    // 10 ms worth of 25 MHz cycles
    localparam int unsigned DEBOUNCE_10MS_25MHZ = 250000;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } deb_state_t;

    // Keep only the highest-priority press: finish > stand > double > hit.
    // Lower-priority presses are dropped, not deferred.
    function automatic logic [N_BTN-1:0] btn_priority_pick(input logic [N_BTN-1:0] i_press);
        logic [N_BTN-1:0] w_pick;
        w_pick = '0;
        if (i_press[BTN_FINISH]) begin
            w_pick[BTN_FINISH] = 1'b1;
        end else if (i_press[BTN_STAND]) begin
            w_pick[BTN_STAND] = 1'b1;
        end else if (i_press[BTN_DOUBLE]) begin
            w_pick[BTN_DOUBLE] = 1'b1;
        end else if (i_press[BTN_HIT]) begin
            w_pick[BTN_HIT] = 1'b1;
        end else begin
            w_pick = '0;
        end
        return w_pick;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: two-flop synchronizer, four-state debounce FSM with a
// saturating-by-construction counter, and registered level/press/release.
//   i_clk      : system clock
//   i_rst      : asynchronous active-high reset
//   i_btn_raw  : raw asynchronous button level, 1 = pressed
//   o_level    : debounced level (high in PRESSED and RELEASE_PEND)
//   o_press    : one-cycle pulse after an accepted press
//   o_release  : one-cycle pulse after an accepted release
// DEBOUNCE_CYCLES legal range is 2..2^20-1.
// -----------------------------------------------------------------------------
module btn_debounce_ch
    import blackjack_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    // Two-flop synchronizer, no logic between stages
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM with registered level and edge pulses.
    // Entering a pending state loads cnt=1 because that sample already counts
    // as the first stable cycle; acceptance happens on the DEBOUNCE_CYCLES-th.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= RELEASED;
            r_cnt     <= CNT_ZERO;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (r_sync2) begin
                        r_state <= PRESS_PEND;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt   <= CNT_ZERO;
                    end
                end
                PRESS_PEND: begin
                    if (!r_sync2) begin
                        r_state <= RELEASED;
                        r_cnt   <= CNT_ZERO;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= PRESSED;
                        r_cnt   <= CNT_ZERO;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!r_sync2) begin
                        r_state <= RELEASE_PEND;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt   <= CNT_ZERO;
                    end
                end
                RELEASE_PEND: begin
                    if (r_sync2) begin
                        r_state   <= PRESSED;
                        r_cnt     <= CNT_ZERO;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= RELEASED;
                        r_cnt     <= CNT_ZERO;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt     <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_cnt   <= CNT_ZERO;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

    btn_debounce_ch_chk #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chk (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_cnt     (r_cnt),
        .i_level   (r_level),
        .i_press   (r_press),
        .i_release (r_release)
    );

endmodule

// File: rtl/btn_debounce_ch_chk.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch_chk
// Property checker bound into each debounce channel.
//   i_clk     : channel clock
//   i_rst     : asynchronous active-high reset (checks disabled while high)
//   i_cnt     : debounce counter
//   i_level   : debounced level
//   i_press   : press pulse
//   i_release : release pulse
// -----------------------------------------------------------------------------
module btn_debounce_ch_chk #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input logic             i_clk,
    input logic             i_rst,
    input logic [CNT_W-1:0] i_cnt,
    input logic             i_level,
    input logic             i_press,
    input logic             i_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The pending states exit at CNT_LAST, so the counter can never pass it
    a_cnt_bound: assert property (@(posedge i_clk) disable iff (i_rst) i_cnt <= CNT_LAST);

    // A channel cannot accept a press and a release in the same cycle
    a_pulse_excl: assert property (@(posedge i_clk) disable iff (i_rst) !(i_press && i_release));

    // Pulses agree with the level they announce
    a_press_lvl: assert property (@(posedge i_clk) disable iff (i_rst) i_press |-> i_level);
    a_rel_lvl:   assert property (@(posedge i_clk) disable iff (i_rst) i_release |-> !i_level);

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Front-end stage for the four player buttons (hit, stand, double, finish).
// Each button is synchronized and debounced independently; the core only
// consumes btn_press so one physical press is one game action.
//   clk_25MHz   : system clock
//   rst         : asynchronous active-high reset
//   btn_raw     : raw button levels, 1 = pressed
//   btn_level   : debounced levels
//   btn_press   : one-cycle pulse per accepted press
//   btn_release : one-cycle pulse per accepted release
//   btn_any     : OR of btn_level
// Build option BTN_PRIORITY_EN: when defined, simultaneous presses are
// reduced to the single highest-priority pulse (finish > stand > double > hit);
// levels and release pulses are unaffected.
// -----------------------------------------------------------------------------
module button_conditioner
    import blackjack_pkg::*;
#(
    parameter int unsigned N_BTN           = blackjack_pkg::N_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ
) (
    input  logic             clk_25MHz,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             btn_any
);

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk     (clk_25MHz),
            .i_rst     (rst),
            .i_btn_raw (btn_raw[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g])
        );
    end

`ifdef BTN_PRIORITY_EN
    // Only the winning press is forwarded; losers still latch their level
    assign btn_press = btn_priority_pick(w_press);
`else
    assign btn_press = w_press;
`endif

    assign btn_level   = w_level;
    assign btn_release = w_release;
    assign btn_any     = |w_level;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int unsigned DEB = 4;

`ifdef BTN_PRIORITY_EN
    localparam logic [3:0] EXP_SIM = 4'b1000;
`else
    localparam logic [3:0] EXP_SIM = 4'b1001;
`endif

    logic       clk_25MHz = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       btn_any;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] acc_p;
    logic [3:0] acc_r;
    logic [3:0] acc_l;

    always #5 clk_25MHz = ~clk_25MHz;

    button_conditioner #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_25MHz   (clk_25MHz),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_any     (btn_any)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and settle
    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance n edges, OR-ing every observed output into the accumulators
    task automatic run_acc(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            acc_p = acc_p | btn_press;
            acc_r = acc_r | btn_release;
            acc_l = acc_l | btn_level;
        end
    endtask

    initial begin
        int n_p;

        rst     = 1'b1;
        btn_raw = 4'b0000;
        wait_n(3);
        chk("rst_level",   btn_level,   4'b0000);
        chk("rst_press",   btn_press,   4'b0000);
        chk("rst_release", btn_release, 4'b0000);
        chk("rst_any",     {3'b000, btn_any}, 4'b0000);
        rst = 1'b0;
        wait_n(2);

        // Clean press on hit: raw sampled at E, pulse visible after E+5
        btn_raw = 4'b0001;
        tick();                     // E
        wait_n(3);                  // E+3
        tick();                     // E+4
        chk("hit_press_early", btn_press, 4'b0000);
        chk("hit_level_early", btn_level, 4'b0000);
        tick();                     // E+5
        chk("hit_press",   btn_press,   4'b0001);
        chk("hit_level",   btn_level,   4'b0001);
        chk("hit_any",     {3'b000, btn_any}, 4'b0001);
        chk("hit_no_rel",  btn_release, 4'b0000);
        tick();                     // E+6
        chk("hit_press_end", btn_press, 4'b0000);
        chk("hit_level_hold", btn_level, 4'b0001);
        btn_raw = 4'b0000;
        wait_n(8);
        chk("hit_rel_level", btn_level, 4'b0000);

        // Bounce on stand: 1,0,1,0 one cycle each then 0
        acc_p = 4'b0000; acc_r = 4'b0000; acc_l = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            btn_raw = ((i % 2) == 0) ? 4'b0010 : 4'b0000;
            run_acc(1);
        end
        btn_raw = 4'b0000;
        run_acc(10);
        chk("bounce_press",   acc_p, 4'b0000);
        chk("bounce_release", acc_r, 4'b0000);
        chk("bounce_level",   acc_l, 4'b0000);

        // Stable for DEB-1 cycles only: still rejected
        acc_p = 4'b0000; acc_r = 4'b0000; acc_l = 4'b0000;
        btn_raw = 4'b0010;
        run_acc(3);
        btn_raw = 4'b0000;
        run_acc(10);
        chk("short3_press", acc_p, 4'b0000);
        chk("short3_level", acc_l, 4'b0000);

        // Stable for exactly DEB cycles: accepted, then released
        btn_raw = 4'b0010;
        tick();                     // E
        wait_n(3);                  // E+3
        btn_raw = 4'b0000;
        tick();                     // E+4
        chk("exact4_press_early", btn_press, 4'b0000);
        tick();                     // E+5
        chk("exact4_press", btn_press, 4'b0010);
        chk("exact4_level", btn_level, 4'b0010);
        wait_n(3);                  // E+8
        chk("exact4_rel_early", btn_release, 4'b0000);
        tick();                     // E+9
        chk("exact4_release", btn_release, 4'b0010);
        chk("exact4_level_off", btn_level, 4'b0000);
        wait_n(4);

        // Release on double after a 20-cycle hold
        btn_raw = 4'b0100;
        wait_n(20);
        chk("dbl_level_held", btn_level, 4'b0100);
        btn_raw = 4'b0000;
        tick();                     // F
        wait_n(3);                  // F+3
        tick();                     // F+4
        chk("dbl_rel_early",   btn_release, 4'b0000);
        chk("dbl_level_pend",  btn_level,   4'b0100);
        tick();                     // F+5
        chk("dbl_release",     btn_release, 4'b0100);
        chk("dbl_level_off",   btn_level,   4'b0000);
        chk("dbl_any_off",     {3'b000, btn_any}, 4'b0000);
        chk("dbl_no_press",    btn_press,   4'b0000);
        tick();                     // F+6
        chk("dbl_release_end", btn_release, 4'b0000);
        wait_n(4);

        // Simultaneous hit + finish
        btn_raw = 4'b1001;
        tick();                     // E
        wait_n(3);
        tick();                     // E+4
        chk("sim_press_early", btn_press, 4'b0000);
        tick();                     // E+5
        chk("sim_press", btn_press, EXP_SIM);
        chk("sim_level", btn_level, 4'b1001);
        tick();
        chk("sim_press_end", btn_press, 4'b0000);
        btn_raw = 4'b0000;
        tick();                     // F
        wait_n(4);                  // F+4
        tick();                     // F+5
        chk("sim_release", btn_release, 4'b1001);
        chk("sim_level_off", btn_level, 4'b0000);
        wait_n(4);

        // Reset mid-debounce: hit already pressed, finish pending with cnt=2
        btn_raw = 4'b0001;
        wait_n(8);
        chk("rstmid_hit_level", btn_level, 4'b0001);
        btn_raw = 4'b1001;
        tick();                     // E
        wait_n(3);                  // E+3: finish in PRESS_PEND, cnt=2
        rst = 1'b1;
        #1;
        chk("rstmid_level", btn_level, 4'b0000);
        chk("rstmid_any",   {3'b000, btn_any}, 4'b0000);
        chk("rstmid_press", btn_press, 4'b0000);
        tick();
        chk("rstmid_level_hold", btn_level, 4'b0000);
        rst = 1'b0;
        tick();                     // E'
        wait_n(3);
        tick();                     // E'+4
        chk("rstmid_press_early", btn_press, 4'b0000);
        tick();                     // E'+5
        chk("rstmid_repress", btn_press, EXP_SIM);
        chk("rstmid_relevel", btn_level, 4'b1001);
        tick();
        chk("rstmid_press_end", btn_press, 4'b0000);
        btn_raw = 4'b0000;
        wait_n(10);

        // Long hold: exactly one press pulse on stand
        n_p = 0;
        acc_p = 4'b0000;
        btn_raw = 4'b0010;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (btn_press[1]) n_p++;
            acc_p = acc_p | btn_press;
        end
        chk("long_press_count", 4'(n_p), 4'd1);
        chk("long_press_chan",  acc_p, 4'b0010);
        chk("long_level",       btn_level, 4'b0010);
        btn_raw = 4'b0000;
        wait_n(10);
        chk("long_level_off", btn_level, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
